vx_lz_decoder: RTL and testbench

VX_LZ_DECODER -- requirements
Module: VX_lz_decoder

---
 rtl/vx_lz_decoder_pkg.sv | 21 ++
 rtl/vx_lz_decoder_onehot.sv | 23 ++
 rtl/vx_lz_decoder.sv | 144 ++++++++++++++
 tb/tb_vx_lz_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_lz_decoder_pkg.sv
// Helpers shared by vx_lz_decoder and its one-hot sub-module.
// Optional mask accumulator is enabled by defining VX_LZ_DECODER_MASK_EN.
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif
`ifndef TRACING_OFF
`define TRACING_OFF
`endif
`ifndef TRACING_ON
`define TRACING_ON
`endif

package vx_lz_decoder_pkg;

  // Zero count that selects a given output bit: trailing zeros when
  // reversed, leading zeros from the MSB otherwise.
  function automatic int lz_count_for_bit(int bit_idx, int n, int reverse);
    return (reverse != 0) ? bit_idx : (n - 1 - bit_idx);
  endfunction

endpackage

// File: rtl/vx_lz_decoder_onehot.sv
// Combinational zero-count to one-hot conversion, direction set by REVERSE.
`TRACING_OFF
module vx_lz_decoder_onehot
  import vx_lz_decoder_pkg::*;
#(
  parameter int N       = 2,
  parameter int REVERSE = 0,
  parameter int LOGN    = `LOG2UP(N)
) (
  input  logic [LOGN:0] cnt_i,
  input  logic          en_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = en_i && (int'(cnt_i) == lz_count_for_bit(i, N, REVERSE));
    end
  end

endmodule
`TRACING_ON

// File: rtl/vx_lz_decoder.sv
// Expands a (zero count, length) request into a stream of one-hot beats.
// Define VX_LZ_DECODER_MASK_EN to build the accumulated thermometer mask.
`TRACING_OFF
module vx_lz_decoder
  import vx_lz_decoder_pkg::*;
#(
  parameter int N       = 2,
  parameter int REVERSE = 0,
  parameter int LOGN    = `LOG2UP(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  output logic          ready_in,
  input  logic [LOGN-1:0] count_in,
  input  logic [LOGN:0] len_in,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [N-1:0]  data_out,
  output logic [N-1:0]  mask_out,
  output logic          last_out,
  output logic          err_out,
  output logic          busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a held beat stays unchanged.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [LOGN:0] EDGE_CNT = (LOGN+1)'(N - 1);
  localparam logic [LOGN:0] N_CNT    = (LOGN+1)'(N);

  state_e        state_q, state_d;
  logic [LOGN:0] cnt_q, cnt_d;
  logic [LOGN:0] rem_q, rem_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  beat_d;
  logic          load_beat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    last_d    = last_q;
    err_d     = 1'b0;
    load_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if ({1'b0, count_in} >= N_CNT) begin
            err_d = 1'b1;
          end else if (len_in != '0) begin
            state_d   = BUSY;
            cnt_d     = {1'b0, count_in};
            rem_d     = len_in - 1'b1;
            load_beat = 1'b1;
          end
        end
      end
      BUSY: begin
        if (ready_out) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Both directions reach the vector edge when the zero count hits N-1.
    if (load_beat) begin
      last_d = (rem_d == '0) || (cnt_d == EDGE_CNT);
    end
  end

  vx_lz_decoder_onehot #(
    .N       (N),
    .REVERSE (REVERSE),
    .LOGN    (LOGN)
  ) u_onehot (
    .cnt_i    (cnt_d),
    .en_i     (load_beat),
    .onehot_o (beat_d)
  );

  assign data_d = load_beat ? beat_d : ((state_d == BUSY) ? data_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

`ifdef VX_LZ_DECODER_MASK_EN
  logic [N-1:0] mask_q, mask_d;

  // A fresh request restarts the accumulation from its first beat.
  always_comb begin
    mask_d = (state_d == BUSY) ? mask_q : '0;
    if (load_beat) begin
      mask_d = ((state_q == IDLE) ? '0 : mask_q) | beat_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_out = mask_q;
`else
  assign mask_out = '0;
`endif

  assign ready_in  = (state_q == IDLE) && !reset;
  assign valid_out = (state_q == BUSY);
  assign data_out  = data_q;
  assign last_out  = last_q;
  assign err_out   = err_q;
  assign busy_o    = (state_q == BUSY);

endmodule
`TRACING_ON

// File: tb/tb_vx_lz_decoder.sv
// Drives three decoder variants (N=8 fwd, N=8 rev, N=6 fwd) with shared
// requests and checks each against a beat-list reference model.
module tb_vx_lz_decoder;

`ifdef VX_LZ_DECODER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [2:0] count_in = '0;
  logic [3:0] len_in = '0;
  logic       ready_out = 1'b0;

  logic [2:0] rdy_w, vld_w, last_w, err_w, busy_w;
  logic [7:0] data_w[3];
  logic [7:0] mask_w[3];
  logic [5:0] data6, mask6;

  int n_of[3]   = '{8, 8, 6};
  int rev_of[3] = '{0, 1, 0};

  // Expected beats per variant: {last, mask[7:0], data[7:0]}.
  logic [16:0] exp_q[3][$];
  bit          err_exp[3];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vx_lz_decoder #(.N(8), .REVERSE(0)) u_fwd8 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rdy_w[0]),
    .count_in(count_in), .len_in(len_in), .valid_out(vld_w[0]),
    .ready_out(ready_out), .data_out(data_w[0]), .mask_out(mask_w[0]),
    .last_out(last_w[0]), .err_out(err_w[0]), .busy_o(busy_w[0])
  );

  vx_lz_decoder #(.N(8), .REVERSE(1)) u_rev8 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rdy_w[1]),
    .count_in(count_in), .len_in(len_in), .valid_out(vld_w[1]),
    .ready_out(ready_out), .data_out(data_w[1]), .mask_out(mask_w[1]),
    .last_out(last_w[1]), .err_out(err_w[1]), .busy_o(busy_w[1])
  );

  vx_lz_decoder #(.N(6), .REVERSE(0)) u_fwd6 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rdy_w[2]),
    .count_in(count_in), .len_in(len_in), .valid_out(vld_w[2]),
    .ready_out(ready_out), .data_out(data6), .mask_out(mask6),
    .last_out(last_w[2]), .err_out(err_w[2]), .busy_o(busy_w[2])
  );

  assign data_w[2] = {2'b00, data6};
  assign mask_w[2] = {2'b00, mask6};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: list every beat the request should produce, straight from
  // the position rule and the two stop conditions.
  task automatic model_accept(input int d);
    int n, zc, p;
    logic [7:0] oh, acc;
    bit last;
    n = n_of[d];
    acc = '0;
    if (int'(count_in) >= n) begin
      err_exp[d] = 1'b1;
    end else begin
      for (int k = 0; k < int'(len_in); k++) begin
        zc = int'(count_in) + k;
        p = (rev_of[d] != 0) ? zc : (n - 1 - zc);
        oh = 8'(1) << p;
        acc = acc | oh;
        last = (k == int'(len_in) - 1) || ((rev_of[d] != 0) ? (p == n - 1) : (p == 0));
        exp_q[d].push_back({last, (MASK_EN ? acc : 8'h00), oh});
        if (last) break;
      end
    end
  endtask

  task automatic check_all();
    logic [16:0] f;
    bit busy;
    for (int d = 0; d < 3; d++) begin
      busy = (exp_q[d].size() > 0);
      f = busy ? exp_q[d][0] : 17'h0;
      chk($sformatf("d%0d valid_out", d), {31'b0, vld_w[d]}, {31'b0, busy});
      chk($sformatf("d%0d ready_in", d), {31'b0, rdy_w[d]}, {31'b0, !reset && !busy});
      chk($sformatf("d%0d busy", d), {31'b0, busy_w[d]}, {31'b0, busy});
      chk($sformatf("d%0d err_out", d), {31'b0, err_w[d]}, {31'b0, err_exp[d]});
      chk($sformatf("d%0d data_out", d), {24'b0, data_w[d]}, {24'b0, f[7:0]});
      chk($sformatf("d%0d mask_out", d), {24'b0, mask_w[d]}, {24'b0, f[15:8]});
      chk($sformatf("d%0d last_out", d), {31'b0, last_w[d]}, {31'b0, f[16]});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        err_exp[d] = 1'b0;
        if (exp_q[d].size() > 0) begin
          if (ready_out) void'(exp_q[d].pop_front());
        end else if (valid_in) begin
          model_accept(d);
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic bit any_busy();
    return (exp_q[0].size() > 0) || (exp_q[1].size() > 0) || (exp_q[2].size() > 0);
  endfunction

  task automatic wait_idle(input bit rand_ready);
    int b;
    b = 0;
    while (any_busy() && b < 200) begin
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      b++;
    end
    chk("idle_timeout", {31'b0, any_busy()}, 32'h0);
  endtask

  task automatic send(input int c, input int l);
    valid_in = 1'b1;
    count_in = 3'(c);
    len_in   = 4'(l);
    cycle();
    valid_in = 1'b0;
  endtask

  initial begin
    // Reset state, including ready_in low while reset is held.
    @(negedge clk);
    #1 check_all();
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Forward 3-beat request at full throughput.
    ready_out = 1'b1;
    send(2, 3);
    chk("fwd_b0_data", {24'b0, data_w[0]}, 32'h20);
    cycle();
    chk("fwd_b1_data", {24'b0, data_w[0]}, 32'h10);
    cycle();
    chk("fwd_b2_data", {24'b0, data_w[0]}, 32'h08);
    chk("fwd_b2_last", {31'b0, last_w[0]}, 32'h1);
    chk("fwd_b2_mask", {24'b0, mask_w[0]}, MASK_EN ? 32'h38 : 32'h0);
    wait_idle(1'b0);

    // Reverse request clamped at the top bit.
    send(5, 6);
    chk("rev_b0_data", {24'b0, data_w[1]}, 32'h20);
    cycle();
    cycle();
    chk("rev_b2_data", {24'b0, data_w[1]}, 32'h80);
    chk("rev_b2_last", {31'b0, last_w[1]}, 32'h1);
    cycle();
    chk("rev_ready_after", {31'b0, rdy_w[1]}, 32'h1);
    wait_idle(1'b0);

    // Back-pressure on beat 0.
    ready_out = 1'b0;
    send(0, 2);
    cycle();
    cycle();
    chk("hold_data", {24'b0, data_w[0]}, 32'h80);
    ready_out = 1'b1;
    cycle();
    chk("after_hold_data", {24'b0, data_w[0]}, 32'h40);
    chk("after_hold_last", {31'b0, last_w[0]}, 32'h1);
    wait_idle(1'b0);

    // Zero length, then out-of-range count on the N=6 variant.
    send(3, 0);
    cycle();
    send(7, 2);
    chk("n6_err_pulse", {31'b0, err_w[2]}, 32'h1);
    cycle();
    chk("n6_err_gone", {31'b0, err_w[2]}, 32'h0);
    wait_idle(1'b0);
    send(6, 1);
    wait_idle(1'b0);

    // Reset in the middle of a long request.
    send(0, 8);
    cycle();
    cycle();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      err_exp[d] = 1'b0;
    end
    #1 check_all();
    chk("rst_mid_data", {24'b0, data_w[0]}, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    #1 check_all();
    for (int i = 0; i < 6; i++) begin
      ready_out = 1'($urandom_range(0, 1));
      cycle();
    end

    // Random requests under random back-pressure.
    for (int i = 0; i < 60; i++) begin
      wait_idle(1'b1);
      ready_out = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
      if ($urandom_range(0, 3) == 0) cycle();
    end
    wait_idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
